demux14_frame: RTL and testbench

// - Sequential 1:4 demultiplexer, the receive end of the 4:1 mux datapath: takes a

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux14_frame_gap_timer.sv | 32 +++
 rtl/demux14_frame.sv | 120 ++++++++++++
 tb/tb_demux14_frame.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and lane indices for the 1:4 frame demux
package demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

endpackage

// File: rtl/demux14_frame_gap_timer.sv
// rtl/demux14_frame_gap_timer.sv - saturating idle-cycle counter for in-frame gap timeout
// expire is combinational so the top can let a same-cycle sample win over the timeout.
module gap_timer #(
  parameter int MAX_GAP = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MAX_GAP + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_GAP - 1);
  localparam logic [CW-1:0] SAT  = CW'(MAX_GAP);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the idle cycle that would bring the count up to MAX_GAP.
  assign expire = enable && (r_count == LAST);

endmodule

// File: rtl/demux14_frame.sv
// rtl/demux14_frame.sv - sof-aligned 1:4 sample demux publishing whole frames atomically
module demux14_frame
  import demux_pkg::*;
#(
  parameter int W       = 1,
  parameter int MAX_GAP = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         sync_err
);

  state_t       r_state;
  logic [1:0]   r_slot;
  logic [W-1:0] r_cap_a, r_cap_b, r_cap_c;
  logic [W-1:0] r_a, r_b, r_c, r_d;
  logic         r_frame_valid;
  logic         r_sync_err;

  logic w_gap_clear;
  logic w_gap_enable;
  logic w_gap_expire;

  assign w_gap_clear  = (r_state == HUNT) || din_valid;
  assign w_gap_enable = (r_state == RUN) && !din_valid;

  gap_timer #(.MAX_GAP(MAX_GAP)) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_gap_clear),
    .enable (w_gap_enable),
    .expire (w_gap_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_slot        <= LANE_A;
      r_cap_a       <= '0;
      r_cap_b       <= '0;
      r_cap_c       <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_d           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      case (r_state)
        HUNT: begin
          if (din_valid && sof) begin
            r_cap_a <= din;
            r_slot  <= LANE_B;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (din_valid && sof) begin
            // Early sof: drop the partial frame and restart on this sample.
            r_sync_err <= 1'b1;
            r_cap_a    <= din;
            r_slot     <= LANE_B;
          end else if (din_valid) begin
            case (r_slot)
              LANE_B: begin
                r_cap_b <= din;
                r_slot  <= LANE_C;
              end
              LANE_C: begin
                r_cap_c <= din;
                r_slot  <= LANE_D;
              end
              LANE_D: begin
                r_a           <= r_cap_a;
                r_b           <= r_cap_b;
                r_c           <= r_cap_c;
                r_d           <= din;
                r_frame_valid <= 1'b1;
                r_slot        <= LANE_A;
                r_state       <= HUNT;
              end
              default: begin
                r_slot  <= LANE_A;
                r_state <= HUNT;
              end
            endcase
          end else if (w_gap_expire) begin
            r_sync_err <= 1'b1;
            r_slot     <= LANE_A;
            r_state    <= HUNT;
          end
        end
        default: begin
          r_slot  <= LANE_A;
          r_state <= HUNT;
        end
      endcase
    end
  end

  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;
  assign d           = r_d;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_demux14_frame.sv
// tb/tb_demux14_frame.sv - scoreboard bench for demux14_frame
module tb_demux14_frame;

  logic       clk;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       sof;
  logic [0:0] a, b, c, d;
  logic       frame_valid;
  logic [1:0] slot;
  logic       sync_err;

  logic [3:0] exp_q[$];
  int n_checks;
  int n_pass;
  int n_fv;
  int n_se;

  demux14_frame #(.W(1), .MAX_GAP(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        n_fv++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_frame got=%b%b%b%b required=none", a, b, c, d);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if ({a, b, c, d} !== e)
            $display("FAIL frame_lanes got=%b required=%b", {a, b, c, d}, e);
          else
            n_pass++;
        end
        n_checks++;
        if (sync_err !== 1'b0)
          $display("FAIL pulse_exclusive got sync_err=%b required=0", sync_err);
        else
          n_pass++;
      end
      if (sync_err) n_se++;
    end
  end

  task automatic send(input logic s, input logic dv);
    din_valid = 1'b1;
    sof       = s;
    din       = dv;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 0; din_valid = 0; sof = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a, b, c, d, slot, frame_valid, sync_err} !== 8'b0)
      $display("FAIL reset_state got=%b required=%b", {a, b, c, d, slot, frame_valid, sync_err}, 8'b0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_clean;
    exp_q.push_back(4'b1011);
    send(1, 1); send(0, 0); send(0, 1); send(0, 1);
    n_checks++;
    if (frame_valid !== 1'b1 || {a, b, c, d} !== 4'b1011 || slot !== 2'd0)
      $display("FAIL clean_latency got fv=%b lanes=%b slot=%0d required fv=1 lanes=1011 slot=0",
               frame_valid, {a, b, c, d}, slot);
    else n_pass++;
    idle(1);
    n_checks++;
    if (frame_valid !== 1'b0)
      $display("FAIL clean_pulse_width got fv=%b required=0", frame_valid);
    else n_pass++;
  endtask

  task automatic test_bubbles;
    int se0, fv0;
    se0 = n_se; fv0 = n_fv;
    exp_q.push_back(4'b1011);
    send(1, 1); idle(3); send(0, 0); idle(3); send(0, 1); idle(3); send(0, 1);
    idle(2);
    n_checks++;
    if (n_se != se0 || n_fv != fv0 + 1)
      $display("FAIL bubbles got se=%0d fv=%0d required se=0 fv=1", n_se - se0, n_fv - fv0);
    else n_pass++;
  endtask

  task automatic test_early_sof;
    int se0;
    se0 = n_se;
    exp_q.push_back(4'b0101);
    send(1, 1); send(0, 0); send(1, 0);
    n_checks++;
    if (sync_err !== 1'b1 || {a, b, c, d} !== 4'b1011 || slot !== 2'd1)
      $display("FAIL early_sof got se=%b lanes=%b slot=%0d required se=1 lanes=1011 slot=1",
               sync_err, {a, b, c, d}, slot);
    else n_pass++;
    send(0, 1); send(0, 0);
    n_checks++;
    if ({a, b, c, d} !== 4'b1011)
      $display("FAIL early_sof_hold got lanes=%b required=1011", {a, b, c, d});
    else n_pass++;
    send(0, 1);
    idle(2);
    n_checks++;
    if (n_se != se0 + 1)
      $display("FAIL early_sof_count got=%0d required=1", n_se - se0);
    else n_pass++;
  endtask

  task automatic test_timeout;
    send(1, 1);
    idle(14);
    n_checks++;
    if (sync_err !== 1'b0 || slot !== 2'd1)
      $display("FAIL timeout_early got se=%b slot=%0d required se=0 slot=1", sync_err, slot);
    else n_pass++;
    idle(1);
    n_checks++;
    if (sync_err !== 1'b1 || slot !== 2'd0 || {a, b, c, d} !== 4'b0101)
      $display("FAIL timeout_fire got se=%b slot=%0d lanes=%b required se=1 slot=0 lanes=0101",
               sync_err, slot, {a, b, c, d});
    else n_pass++;
    idle(1);
    exp_q.push_back(4'b1100);
    send(1, 1);
    idle(14);
    send(0, 1);
    n_checks++;
    if (sync_err !== 1'b0 || slot !== 2'd2)
      $display("FAIL timeout_accept got se=%b slot=%0d required se=0 slot=2", sync_err, slot);
    else n_pass++;
    send(0, 0); send(0, 0);
    idle(2);
  endtask

  task automatic test_hunt_garbage;
    int se0, fv0;
    se0 = n_se; fv0 = n_fv;
    for (int i = 0; i < 5; i++) send(0, 1'($urandom_range(0, 1)));
    idle(1);
    n_checks++;
    if (n_se != se0 || n_fv != fv0 || {a, b, c, d} !== 4'b1100 || slot !== 2'd0)
      $display("FAIL hunt_garbage got se=%0d fv=%0d lanes=%b slot=%0d required 0 0 1100 0",
               n_se - se0, n_fv - fv0, {a, b, c, d}, slot);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int se0;
    logic [3:0] f;
    se0 = n_se;
    for (int i = 0; i < 6; i++) begin
      f = 4'($urandom_range(0, 15));
      exp_q.push_back(f);
      send(1, f[3]); send(0, f[2]); send(0, f[1]); send(0, f[0]);
    end
    // sof landing on slot 3 is still an early sof
    send(1, 1); send(0, 1); send(0, 1); send(1, 0);
    exp_q.push_back(4'b0110);
    send(0, 1); send(0, 1); send(0, 0);
    idle(2);
    n_checks++;
    if (n_se != se0 + 1)
      $display("FAIL b2b_sync_err got=%0d required=1", n_se - se0);
    else n_pass++;
  endtask

  task automatic test_midrun_reset;
    int se0, fv0;
    send(1, 1); send(0, 1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a, b, c, d} !== 4'b0 || slot !== 2'd0)
      $display("FAIL midrun_reset got lanes=%b slot=%0d required lanes=0000 slot=0", {a, b, c, d}, slot);
    else n_pass++;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    se0 = n_se; fv0 = n_fv;
    send(0, 1); send(0, 1); idle(3);
    n_checks++;
    if (n_se != se0 || n_fv != fv0 || {a, b, c, d} !== 4'b0)
      $display("FAIL post_reset_quiet got se=%0d fv=%0d lanes=%b required 0 0 0000",
               n_se - se0, n_fv - fv0, {a, b, c, d});
    else n_pass++;
    exp_q.push_back(4'b1001);
    send(1, 1); send(0, 0); send(0, 0); send(0, 1);
    idle(2);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fv = 0; n_se = 0;
    test_reset();
    test_clean();
    test_bubbles();
    test_early_sof();
    test_timeout();
    test_hunt_garbage();
    test_back_to_back();
    test_midrun_reset();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
